// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy-bird game blocks (controller, bird, pipes).
package flappy_pkg;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned FLAP_W = 8;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned LOCK_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10
  } game_state_t;

  localparam logic [FLAP_W-1:0] FLAP_ON   = 8'hFF;
  localparam logic [FLAP_W-1:0] FLAP_OFF  = 8'h00;
  localparam logic [KEY_W-1:0]  KEY_SPACE = 8'h2C;
  localparam logic [BCD_W-1:0]  BCD_MAX   = 8'h99;

endpackage

// File: rtl/game_ctrl_fsm_bcd2_inc.sv
// Combinational two-digit BCD increment, saturating at 99.
module bcd2_inc
  import flappy_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [BCD_W-1:0] o_bcd_c
);

  logic [3:0] w_tens;
  logic [3:0] w_ones;

  assign w_tens = i_bcd[7:4];
  assign w_ones = i_bcd[3:0];

  always_comb begin
    o_bcd_c = i_bcd;
    if (i_bcd == BCD_MAX) begin
      o_bcd_c = BCD_MAX;
    end else if (w_ones == 4'd9) begin
      o_bcd_c = {4'(w_tens + 4'd1), 4'd0};
    end else begin
      o_bcd_c = {w_tens, 4'(w_ones + 4'd1)};
    end
  end

endmodule

// File: rtl/game_ctrl_fsm.sv
// Flappy-bird game controller: IDLE/PLAY/OVER sequencing, flap strobe for the bird
// block, BCD score and best score for the HUD.
module game_ctrl_fsm
  import flappy_pkg::*;
#(
  parameter logic [KEY_W-1:0]  SPACE_CODE  = KEY_SPACE,
  parameter logic [LOCK_W-1:0] LOCK_FRAMES = 6'd60
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [KEY_W-1:0]  keycode,
  input  logic              is_bottom,
  input  logic              pipe_hit,
  input  logic              pipe_pass,
  output logic [1:0]        game_state,
  output logic [FLAP_W-1:0] space_trigger,
  output logic [BCD_W-1:0]  score_bcd,
  output logic [BCD_W-1:0]  best_bcd,
  output logic              new_best
);

  logic              r_fd;
  logic              r_tick;
  logic              r_key_q;
  game_state_t       r_state;
  logic              r_armed;
  logic [FLAP_W-1:0] r_trigger;
  logic [BCD_W-1:0]  r_score;
  logic [BCD_W-1:0]  r_best;
  logic              r_new_best;
  logic [LOCK_W-1:0] r_lock;

  logic              w_key_dn;
  logic              w_press;
  logic              w_hit;
  logic [BCD_W-1:0]  w_score_inc;

  game_state_t       w_state_nxt;
  logic              w_armed_nxt;
  logic [BCD_W-1:0]  w_score_nxt;
  logic [BCD_W-1:0]  w_best_nxt;
  logic              w_new_best_nxt;
  logic [LOCK_W-1:0] w_lock_nxt;

  assign w_key_dn = (keycode == SPACE_CODE);
  assign w_press  = w_key_dn & ~r_key_q;
  assign w_hit    = is_bottom | pipe_hit;

  bcd2_inc u_score_inc (
    .i_bcd   (r_score),
    .o_bcd_c (w_score_inc)
  );

  // Next-state, flap arming, scoring and lock countdown.
  always_comb begin
    w_state_nxt    = r_state;
    w_armed_nxt    = r_armed;
    w_score_nxt    = r_score;
    w_best_nxt     = r_best;
    w_new_best_nxt = r_new_best;
    w_lock_nxt     = r_lock;

    // Set beats clear so a press in the tick cycle still flaps next frame.
    if (w_press && (r_state != ST_OVER)) begin
      w_armed_nxt = 1'b1;
    end else if (r_tick) begin
      w_armed_nxt = 1'b0;
    end

    unique case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_state_nxt    = ST_PLAY;
          w_score_nxt    = '0;
          w_new_best_nxt = 1'b0;
        end
      end
      ST_PLAY: begin
        if (w_hit) begin
          w_state_nxt = ST_OVER;
          w_lock_nxt  = LOCK_FRAMES;
          w_armed_nxt = 1'b0;
          if (r_score > r_best) begin
            w_best_nxt     = r_score;
            w_new_best_nxt = 1'b1;
          end
        end else if (pipe_pass) begin
          w_score_nxt = w_score_inc;
        end
      end
      ST_OVER: begin
        if (w_press && (r_lock == '0)) begin
          w_state_nxt = ST_IDLE;
        end
        if (r_tick && (r_lock != '0)) begin
          w_lock_nxt = LOCK_W'(r_lock - 1'b1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fd       <= 1'b0;
      r_tick     <= 1'b0;
      r_key_q    <= 1'b0;
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_trigger  <= FLAP_OFF;
      r_score    <= '0;
      r_best     <= '0;
      r_new_best <= 1'b0;
      r_lock     <= '0;
    end else begin
      r_fd       <= frame_clk;
      r_tick     <= frame_clk & ~r_fd;
      r_key_q    <= w_key_dn;
      r_state    <= w_state_nxt;
      r_armed    <= w_armed_nxt;
      r_trigger  <= w_armed_nxt ? FLAP_ON : FLAP_OFF;
      r_score    <= w_score_nxt;
      r_best     <= w_best_nxt;
      r_new_best <= w_new_best_nxt;
      r_lock     <= w_lock_nxt;
    end
  end

  assign game_state    = r_state;
  assign space_trigger = r_trigger;
  assign score_bcd     = r_score;
  assign best_bcd      = r_best;
  assign new_best      = r_new_best;

endmodule
